// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding and PC
// alignment constants.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    localparam int INST_BYTES = 4;

    // Low PC bits that are always zero for word-aligned instructions.
    localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding read on the instruction bus,
// valid/ready hand-off to the decoder, and PC redirects from execute.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                    pc_width   = 32,
    parameter int                    inst_width = 32,
    parameter logic [pc_width-1:0]   pc_init    = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ir_addr_valid,
    input  logic                     ir_addr_ready,
    output logic [pc_width-1:0]      ir_addr,
    input  logic                     ir_data_valid,
    output logic                     ir_data_ready,
    input  logic [inst_width-1:0]    ir_data,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [inst_width-1:0]    inst,
    output logic [pc_width-1:0]      inst_pc,
    input  logic                     pc_load,
    input  logic [pc_width-1:0]      pc_target
);

    fetch_state_e              state_q, state_d;
    logic [pc_width-1:0]       pc_q, pc_d;
    logic                      discard_q, discard_d;
    logic [inst_width-1:0]     inst_q, inst_d;
    logic [pc_width-1:0]       inst_pc_q, inst_pc_d;

    logic [pc_width-1:0]       pc_inc;
    logic [pc_width-1:0]       redirect_pc;

    assign pc_inc      = pc_q + pc_width'(INST_BYTES);
    assign redirect_pc = pc_target & ~pc_width'(PC_ALIGN_MASK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pc_q      <= pc_init;
            discard_q <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= pc_init;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    // A redirect always wins over the sequential pc+4; discard marks the
    // single in-flight read whose data must be thrown away when it returns.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (pc_load) begin
                    pc_d = redirect_pc;
                end
                if (ir_addr_ready) begin
                    state_d   = WAIT;
                    discard_d = pc_load;
                end
            end
            WAIT: begin
                if (pc_load) begin
                    pc_d = redirect_pc;
                end
                if (ir_data_valid) begin
                    if (discard_q || pc_load) begin
                        discard_d = 1'b0;
                        state_d   = REQ;
                    end else begin
                        inst_d    = ir_data;
                        inst_pc_d = pc_q;
                        state_d   = HOLD;
                    end
                end else if (pc_load) begin
                    discard_d = 1'b1;
                end
            end
            HOLD: begin
                if (pc_load) begin
                    pc_d    = redirect_pc;
                    state_d = REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_inc;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ir_addr_valid = (state_q == REQ);
    assign ir_addr       = pc_q;
    assign ir_data_ready = (state_q == WAIT);
    assign inst_valid    = (state_q == HOLD);
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the instruction decoder. Holds the program counter and issues one read per instruction on the instruction-read bus channels (address, then data). It presents the fetched word and its PC to the decoder through a valid/ready handshake. It also accepts PC redirects from the execute stage (branch/jump), discarding any fetch in flight.

## Interface
- pc_width, 32, width of PC and bus address
- inst_width, 32, instruction word width (matches decoder inst input)
- pc_init, 32'h0, PC value loaded at reset
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-low reset
- ir_addr_valid  output  1  read-address request valid
- ir_addr_ready  input  1  bus accepts address
- ir_addr  output  pc_width  fetch address (current PC)
- ir_data_valid  input  1  read data valid
- ir_data_ready  output  1  fetch unit accepts read data
- ir_data  input  inst_width  read data word
- inst_valid  output  1  inst/inst_pc hold a fetched instruction
- inst_ready  input  1  decoder consumes instruction
- inst  output  inst_width  fetched instruction word
- inst_pc  output  pc_width  PC of inst
- pc_load  input  1  redirect request, single-cycle pulse
- pc_target  input  pc_width  redirect target; bits [1:0] ignored, forced 0

## Operation
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: reset state; unconditionally REQ on first clock after rst deasserts.
- REQ: ir_addr_valid=1, ir_addr=pc. On ir_addr_valid&ir_addr_ready -> WAIT.
- WAIT: ir_data_ready=1. On ir_data_valid: if discard=0, capture inst<=ir_data, inst_pc<=pc, -> HOLD; if discard=1, drop word, clear discard, -> REQ.
- HOLD: inst_valid=1, inst/inst_pc stable. On inst_ready: pc<=pc+4 (wraps mod 2^pc_width), -> REQ.
- Redirect (pc_load=1), any non-IDLE state: pc<={pc_target[pc_width-1:2],2'b00}, overrides pc+4.
  - REQ without address handshake: stay REQ; ir_addr shows new PC next cycle (only case ir_addr may change while valid).
  - REQ with address handshake same cycle: -> WAIT, discard<=1.
  - WAIT without data handshake: discard<=1, stay WAIT. With data handshake same cycle: drop word, -> REQ.
  - HOLD: inst_valid deasserts next cycle, -> REQ (instruction killed whether or not inst_ready was high).
- pc_load in IDLE ignored.
- Exactly one outstanding bus read at any time.

## Timing
- Reset (async assert): state=IDLE, pc=pc_init, discard=0, ir_addr_valid=0, ir_data_ready=0, inst_valid=0, inst=0, inst_pc=pc_init; ir_addr=pc_init.
- Outputs are registered-state decodes; none combinationally depends on ir_addr_ready, ir_data_valid, inst_ready or pc_load.
- Zero-wait bus: REQ (cycle n), WAIT (n+1), HOLD (n+2); inst_valid visible cycle n+2; next REQ cycle n+3 if inst_ready at n+2. Peak throughput 1 instruction / 3 cycles.
- Redirect to first ir_addr_valid with new PC: 1 cycle from REQ/HOLD, WAIT + data wait + 1 from WAIT.
- Reset mid-transaction: all state cleared immediately; bus response arriving after reset release is ignored (ir_data_ready=0 outside WAIT).

## Structure
- Shared package: state encoding localparams (IDLE/REQ/WAIT/HOLD), INST_BYTES=4, PC alignment mask.
- Single module, no sub-module; PC register, discard flag, instruction/PC output registers and 2-bit FSM inline.

## Test plan
- Reset release, pc_init=32'h100, zero-wait bus returning 32'h00500093: ir_addr=0x100 at cycle 1; inst_valid at cycle 3 with inst=32'h00500093, inst_pc=0x100; next ir_addr=0x104.
- ir_addr_ready held low 5 cycles, inst_ready low 4 cycles in HOLD: ir_addr_valid stays high, inst/inst_pc stable, no PC advance until handshakes.
- pc_load with pc_target=0x203 during WAIT, data returns 2 cycles later: returned word dropped, inst_valid never asserted for it, next ir_addr=0x200.
- pc_load in HOLD same cycle as inst_ready, target 0x40: inst_valid low next cycle, ir_addr=0x40 (not pc+4).
- pc=32'hFFFFFFFC, instruction consumed: next ir_addr=0x0.
- rst asserted while in WAIT: all outputs to reset values asynchronously; late ir_data_valid after release ignored, first fetch at pc_init.
